mem_lsu: RTL and testbench

Memory-access stage of the MIPS32 pipeline: sits between the EX/MEM register and `mem_wb`. It performs loads and stores over a request/acknowledge data bus, with big-endian byte-lane steering and load sign/zero extension. While a transfer is outstanding it stalls the front of the pipeline and presents a write-disabled bubble to `mem_wb`. It also detects misaligned accesses and bus timeouts.

---
 rtl/mem_lsu_pkg.sv | 45 ++++
 rtl/mem_lsu_lane.sv | 56 +++++
 rtl/mem_lsu.sv | 133 +++++++++++++
 tb/tb_mem_lsu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MIPS32 memory-access stage: memory-op encodings,
// bus widths and small decode helpers.
package mem_lsu_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int MemOpBus   = 4;

    localparam logic [RegBus-1:0] ZeroWord     = 32'h0000_0000;
    localparam logic              WriteDisable = 1'b0;
    localparam logic              RstEnable    = 1'b1;

    localparam logic [MemOpBus-1:0] MEMOP_NONE = 4'd0;
    localparam logic [MemOpBus-1:0] MEMOP_LB   = 4'd1;
    localparam logic [MemOpBus-1:0] MEMOP_LBU  = 4'd2;
    localparam logic [MemOpBus-1:0] MEMOP_LH   = 4'd3;
    localparam logic [MemOpBus-1:0] MEMOP_LHU  = 4'd4;
    localparam logic [MemOpBus-1:0] MEMOP_LW   = 4'd5;
    localparam logic [MemOpBus-1:0] MEMOP_SB   = 4'd6;
    localparam logic [MemOpBus-1:0] MEMOP_SH   = 4'd7;
    localparam logic [MemOpBus-1:0] MEMOP_SW   = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [MemOpBus-1:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_SW);
    endfunction

    function automatic logic is_store_op(input logic [MemOpBus-1:0] op);
        return (op >= MEMOP_SB) && (op <= MEMOP_SW);
    endfunction

    function automatic logic is_aligned(input logic [MemOpBus-1:0] op,
                                        input logic [1:0]          lo);
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return ~lo[0];
            MEMOP_LW, MEMOP_SW:            return lo == 2'b00;
            default:                       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Big-endian byte-lane steering: byte enables and replicated store data on the
// way out, lane extraction with sign/zero extension on the way back.
module lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [MemOpBus-1:0] mem_op_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [RegBus-1:0]   store_data_i,
    input  logic [RegBus-1:0]   rdata_i,
    output logic [3:0]          sel_o,
    output logic [RegBus-1:0]   wdata_o,
    output logic [RegBus-1:0]   load_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v      = rdata_i[31:24];
        half_v      = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        sel_o       = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = ZeroWord;

        // Lane 0 is the most significant byte.
        case (addr_lo_i)
            2'd0:    byte_v = rdata_i[31:24];
            2'd1:    byte_v = rdata_i[23:16];
            2'd2:    byte_v = rdata_i[15:8];
            default: byte_v = rdata_i[7:0];
        endcase

        case (mem_op_i)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: sel_o = 4'b1000 >> addr_lo_i;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: sel_o = addr_lo_i[1] ? 4'b0011 : 4'b1100;
            MEMOP_LW, MEMOP_SW:            sel_o = 4'b1111;
            default:                       sel_o = 4'b0000;
        endcase

        case (mem_op_i)
            MEMOP_SB: wdata_o = {4{store_data_i[7:0]}};
            MEMOP_SH: wdata_o = {2{store_data_i[15:0]}};
            default:  wdata_o = store_data_i;
        endcase

        case (mem_op_i)
            MEMOP_LB:  load_data_o = {{24{byte_v[7]}}, byte_v};
            MEMOP_LBU: load_data_o = {24'h000000, byte_v};
            MEMOP_LH:  load_data_o = {{16{half_v[15]}}, half_v};
            MEMOP_LHU: load_data_o = {16'h0000, half_v};
            MEMOP_LW:  load_data_o = rdata_i;
            default:   load_data_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MIPS32 memory-access stage: request/acknowledge data bus FSM with stall,
// write-disabled bubble, misalignment detection and bus timeout.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_wReg,
    input  logic [RegAddrBus-1:0] ex_wAddr,
    input  logic [RegBus-1:0]     ex_wData,
    input  logic [MemOpBus-1:0]   ex_memOp,
    input  logic [RegBus-1:0]     ex_memAddr,
    input  logic [RegBus-1:0]     ex_storeData,
    output logic                  mem_wReg,
    output logic [RegAddrBus-1:0] mem_wAddr,
    output logic [RegBus-1:0]     mem_wData,
    output logic                  stall_req,
    output logic                  d_req,
    output logic                  d_we,
    output logic [RegBus-1:0]     d_addr,
    output logic [3:0]            d_sel,
    output logic [RegBus-1:0]     d_wdata,
    input  logic [RegBus-1:0]     d_rdata,
    input  logic                  d_ack,
    output logic                  misalign,
    output logic                  bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    // The IDLE cycle is request cycle 1, so the TIMEOUT-th request cycle is
    // the WAIT cycle whose counter is about to step to TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              op_valid, aligned, acc, is_store, ack_eff, timeout_hit;
    logic [3:0]        lane_sel;
    logic [RegBus-1:0] lane_wdata, lane_ldata;

    lsu_lane u_lane (
        .mem_op_i     (ex_memOp),
        .addr_lo_i    (ex_memAddr[1:0]),
        .store_data_i (ex_storeData),
        .rdata_i      (d_rdata),
        .sel_o        (lane_sel),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_valid    = is_mem_op(ex_memOp);
        aligned     = is_aligned(ex_memOp, ex_memAddr[1:0]);
        acc         = op_valid & aligned;
        is_store    = is_store_op(ex_memOp);
        timeout_hit = 1'b0;
        d_req       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                d_req = acc;
                if (acc && !d_ack) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (d_ack) begin
                    d_req   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    d_req = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ack_eff   = d_req & d_ack;
        stall_req = d_req & ~d_ack;
        bus_err   = timeout_hit;
        misalign  = op_valid & ~aligned;

        d_we    = is_store;
        d_addr  = {ex_memAddr[31:2], 2'b00};
        d_sel   = lane_sel;
        d_wdata = lane_wdata;

        mem_wAddr = ex_wAddr;
        mem_wData = ex_wData;
        mem_wReg  = ex_wReg;
        // Memory ops only write back on a completed load; everything else is a bubble.
        if (op_valid) begin
            mem_wReg = WriteDisable;
            if (!is_store && ack_eff) begin
                mem_wReg  = ex_wReg;
                mem_wData = lane_ldata;
            end
        end

        if (rst == RstEnable) begin
            mem_wReg  = 1'b0;
            mem_wAddr = '0;
            mem_wData = ZeroWord;
            stall_req = 1'b0;
            d_req     = 1'b0;
            d_we      = 1'b0;
            d_addr    = ZeroWord;
            d_sel     = 4'b0000;
            d_wdata   = ZeroWord;
            misalign  = 1'b0;
            bus_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: expected output records are queued as each
// stimulus step is driven and popped for comparison mid-cycle.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wReg;
    logic [4:0]  ex_wAddr;
    logic [31:0] ex_wData;
    logic [3:0]  ex_memOp;
    logic [31:0] ex_memAddr;
    logic [31:0] ex_storeData;
    logic        mem_wReg;
    logic [4:0]  mem_wAddr;
    logic [31:0] mem_wData;
    logic        stall_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        misalign;
    logic        bus_err;

    int passes = 0;
    int total  = 0;

    typedef struct {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic        mis;
        logic        berr;
        bit          chk_wdata;
        bit          chk_bus;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wReg      (ex_wReg),
        .ex_wAddr     (ex_wAddr),
        .ex_wData     (ex_wData),
        .ex_memOp     (ex_memOp),
        .ex_memAddr   (ex_memAddr),
        .ex_storeData (ex_storeData),
        .mem_wReg     (mem_wReg),
        .mem_wAddr    (mem_wAddr),
        .mem_wData    (mem_wData),
        .stall_req    (stall_req),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_sel        (d_sel),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    function automatic exp_t zero_exp();
        exp_t z;
        z.wreg = 1'b0; z.waddr = 5'd0; z.wdata = 32'h0;
        z.stall = 1'b0; z.req = 1'b0; z.we = 1'b0;
        z.addr = 32'h0; z.sel = 4'h0; z.wd = 32'h0;
        z.mis = 1'b0; z.berr = 1'b0;
        z.chk_wdata = 1'b0; z.chk_bus = 1'b0;
        return z;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic wreg, input logic [4:0] waddr, input logic [31:0] wdata);
        ex_memOp     = op;
        ex_memAddr   = addr;
        ex_storeData = sd;
        ex_wReg      = wreg;
        ex_wAddr     = waddr;
        ex_wData     = wdata;
    endtask

    task automatic step(input string tag);
        exp_t x;
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        chk({tag, ".mem_wReg"},  32'(mem_wReg),  32'(x.wreg));
        chk({tag, ".mem_wAddr"}, 32'(mem_wAddr), 32'(x.waddr));
        chk({tag, ".stall_req"}, 32'(stall_req), 32'(x.stall));
        chk({tag, ".d_req"},     32'(d_req),     32'(x.req));
        chk({tag, ".misalign"},  32'(misalign),  32'(x.mis));
        chk({tag, ".bus_err"},   32'(bus_err),   32'(x.berr));
        if (x.chk_wdata)
            chk({tag, ".mem_wData"}, mem_wData, x.wdata);
        if (x.chk_bus) begin
            chk({tag, ".d_we"},    32'(d_we),  32'(x.we));
            chk({tag, ".d_addr"},  d_addr,     x.addr);
            chk({tag, ".d_sel"},   32'(d_sel), 32'(x.sel));
            chk({tag, ".d_wdata"}, d_wdata,    x.wd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset forces every output to zero even with a live access presented.
        rst = 1'b1; d_ack = 1'b1; d_rdata = 32'hDEAD_BEEF;
        drive(4'd5, 32'h100, 32'h0, 1'b1, 5'd5, 32'h1111_1111);
        e = zero_exp(); e.chk_wdata = 1; e.chk_bus = 1;
        step("reset");
        rst = 1'b0;

        // LW, zero-wait
        e = zero_exp(); e.chk_wdata = 1; e.chk_bus = 1;
        e.wreg = 1; e.waddr = 5'd5; e.wdata = 32'hDEAD_BEEF; e.req = 1;
        e.addr = 32'h100; e.sel = 4'hF; e.wd = 32'h0;
        step("lw_ack0");

        // LB at 0x101 with three wait cycles
        d_ack = 1'b0; d_rdata = 32'h12F4_5678;
        drive(4'd1, 32'h101, 32'h0, 1'b1, 5'd6, 32'h2222_2222);
        e = zero_exp(); e.chk_bus = 1;
        e.waddr = 5'd6; e.stall = 1; e.req = 1; e.addr = 32'h100; e.sel = 4'h4;
        for (int i = 0; i < 3; i++) step("lb_wait");
        d_ack = 1'b1;
        e.stall = 0; e.wreg = 1; e.wdata = 32'hFFFF_FFF4; e.chk_wdata = 1;
        step("lb_done");

        // LBU on the same data
        drive(4'd2, 32'h101, 32'h0, 1'b1, 5'd6, 32'h2222_2222);
        e.wdata = 32'h0000_00F4;
        step("lbu");

        // SH at 0x202: lower half lanes, replicated data, no writeback
        drive(4'd7, 32'h202, 32'h0000_ABCD, 1'b1, 5'd7, 32'h3333_3333);
        e = zero_exp(); e.chk_bus = 1;
        e.waddr = 5'd7; e.req = 1; e.we = 1; e.addr = 32'h200; e.sel = 4'h3; e.wd = 32'hABCD_ABCD;
        step("sh");

        // Misaligned LW: no request, no stall
        d_ack = 1'b0;
        drive(4'd5, 32'h102, 32'h0, 1'b1, 5'd8, 32'h4444_4444);
        e = zero_exp(); e.waddr = 5'd8; e.mis = 1;
        step("lw_misalign");

        // NONE passes ALU result through; stray ack is ignored
        d_ack = 1'b1;
        drive(4'd0, 32'h0, 32'h0, 1'b1, 5'd9, 32'hCAFE_F00D);
        e = zero_exp(); e.chk_wdata = 1; e.wreg = 1; e.waddr = 5'd9; e.wdata = 32'hCAFE_F00D;
        step("none");
        drive(4'd12, 32'h0, 32'h0, 1'b1, 5'd10, 32'h0BAD_0BAD);
        e.waddr = 5'd10; e.wdata = 32'h0BAD_0BAD;
        step("op12_as_none");

        // SW never acknowledged: 15 stall cycles then bus_err
        d_ack = 1'b0;
        drive(4'd8, 32'h300, 32'h0102_0304, 1'b0, 5'd11, 32'h0);
        e = zero_exp(); e.chk_bus = 1;
        e.waddr = 5'd11; e.stall = 1; e.req = 1; e.we = 1; e.addr = 32'h300; e.sel = 4'hF; e.wd = 32'h0102_0304;
        for (int i = 0; i < 15; i++) step("sw_wait");
        e.stall = 0; e.req = 0; e.berr = 1;
        step("sw_timeout");
        drive(4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        e = zero_exp();
        step("after_timeout");

        // LH in WAIT, then reset abandons it without bus_err
        d_rdata = 32'h1234_8001;
        drive(4'd3, 32'h104, 32'h0, 1'b1, 5'd3, 32'h5555_5555);
        e = zero_exp(); e.chk_bus = 1;
        e.waddr = 5'd3; e.stall = 1; e.req = 1; e.addr = 32'h104; e.sel = 4'hC;
        step("lh_idle_req");
        step("lh_wait");
        rst = 1'b1;
        e = zero_exp(); e.chk_wdata = 1; e.chk_bus = 1;
        step("lh_reset");
        rst = 1'b0;

        // LH at 0x106 after reset: lower half, sign-extended
        d_ack = 1'b1;
        drive(4'd3, 32'h106, 32'h0, 1'b1, 5'd3, 32'h5555_5555);
        e = zero_exp(); e.chk_wdata = 1; e.chk_bus = 1;
        e.wreg = 1; e.waddr = 5'd3; e.wdata = 32'hFFFF_8001; e.req = 1; e.addr = 32'h104; e.sel = 4'h3;
        step("lh_after_reset");

        // LHU at 0x104 with one wait cycle: upper half, zero-extended
        d_ack = 1'b0;
        drive(4'd4, 32'h104, 32'h0, 1'b1, 5'd4, 32'h6666_6666);
        e = zero_exp(); e.chk_bus = 1;
        e.waddr = 5'd4; e.stall = 1; e.req = 1; e.addr = 32'h104; e.sel = 4'hC;
        step("lhu_wait");
        d_ack = 1'b1;
        e.stall = 0; e.wreg = 1; e.wdata = 32'h0000_1234; e.chk_wdata = 1;
        step("lhu_done");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
